// File: rtl/outpass_pkg.sv
// Shared helpers for the outpass_delay_n pass-through block: depth-field
// width function, default chain length and the default depth-field type.
package outpass_pkg;

    function automatic int unsigned depth_w(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    function automatic int unsigned chain_len(input int unsigned num_ch,
                                              input int unsigned max_depth);
        return num_ch * depth_w(max_depth);
    endfunction

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_MAX_DEPTH = 3;
    localparam int unsigned DEF_DW        = depth_w(DEF_MAX_DEPTH);
    localparam int unsigned DEF_CHAIN_LEN = chain_len(DEF_NUM_CH, DEF_MAX_DEPTH);

    typedef logic [DEF_DW-1:0] depth_t;

endpackage

// File: rtl/outpass_delay_line.sv
// One channel of outpass_delay_n: a MAX_DEPTH-stage shift line with a
// selectable tap (0 = combinational bypass). Optional clock enable on the
// stages when OUTPASS_DELAY_CE_EN is defined; flush always wins over CE.
module outpass_delay_line
    import outpass_pkg::*;
#(
    parameter int unsigned MAX_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
`ifdef OUTPASS_DELAY_CE_EN
    input  logic                           ce,
`endif
    input  logic                           din,
    input  logic [depth_w(MAX_DEPTH)-1:0]  depth,
    output logic                           dout
);

    localparam int unsigned DW = depth_w(MAX_DEPTH);

    logic [MAX_DEPTH-1:0] stage_q;
    logic [MAX_DEPTH-1:0] stage_d;
    logic [MAX_DEPTH-1:0] shifted;
    logic [MAX_DEPTH-1:0] hit;
    logic                 advance;
    int unsigned          depth_sat;

`ifdef OUTPASS_DELAY_CE_EN
    assign advance = ce;
`else
    assign advance = 1'b1;
`endif

    // stage_q[j] holds s(j+1); tap j selected when the saturated depth is j+1
    for (genvar j = 0; j < MAX_DEPTH; j++) begin : g_tap
        if (j == 0) begin : g_first
            assign shifted[j] = din;
        end else begin : g_rest
            assign shifted[j] = stage_q[j-1];
        end
        assign hit[j] = (depth_sat == j + 1);
    end

    // Next stage contents: flush on commit, otherwise shift when advancing
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (advance) begin
            stage_d = shifted;
        end
    end

    // Depth saturation and output tap selection
    always_comb begin
        depth_sat = {{(32-DW){1'b0}}, depth};
        if (depth_sat > MAX_DEPTH) begin
            depth_sat = MAX_DEPTH;
        end
        dout = din;
        if (depth_sat != 0) begin
            dout = |(hit & stage_q);
        end
    end

    // Delay stage register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/outpass_delay_n.sv
// outpass_delay_n: NUM_CH pass-through channels, each with 0..MAX_DEPTH
// cycles of delay. Depths arrive on a serial shadow chain and are committed
// to the active config on the falling edge of MODE (first MODE=0 edge).
// Optional macro OUTPASS_DELAY_CE_EN adds a CE input gating the stages.
module outpass_delay_n
    import outpass_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAX_DEPTH = 3
) (
    input  logic              UserCLK,
    input  logic              RESETn,
`ifdef OUTPASS_DELAY_CE_EN
    input  logic              CE,
`endif
    input  logic [NUM_CH-1:0] I,
    output logic [NUM_CH-1:0] O,
    input  logic              MODE,
    input  logic              CONFin,
    output logic              CONFout
);

    localparam int unsigned DW = depth_w(MAX_DEPTH);
    localparam int unsigned L  = chain_len(NUM_CH, MAX_DEPTH);

    logic [L-1:0] sh_q;
    logic [L-1:0] sh_d;
    logic [L-1:0] sh_shifted;
    logic [L-1:0] act_q;
    logic [L-1:0] act_d;
    logic         mode_q;
    logic         commit;

    assign commit  = mode_q & ~MODE;
    assign CONFout = sh_q[L-1];

    // Chain shifts towards the MSB with CONFin entering at bit 0
    for (genvar i = 0; i < L; i++) begin : g_sh
        if (i == 0) begin : g_in
            assign sh_shifted[i] = CONFin;
        end else begin : g_mid
            assign sh_shifted[i] = sh_q[i-1];
        end
    end

    // Shadow chain shifts in MODE; active config loads only on commit
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (MODE) begin
            sh_d = sh_shifted;
        end
        if (commit) begin
            act_d = sh_q;
        end
    end

    // Configuration and mode registers
    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            sh_q   <= '0;
            act_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            act_q  <= act_d;
            mode_q <= MODE;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        outpass_delay_line #(
            .MAX_DEPTH(MAX_DEPTH)
        ) u_line (
            .clk  (UserCLK),
            .rstn (RESETn),
            .flush(commit),
`ifdef OUTPASS_DELAY_CE_EN
            .ce   (CE),
`endif
            .din  (I[k]),
            .depth(act_q[k*DW +: DW]),
            .dout (O[k])
        );
    end

endmodule

// File: tb/tb_outpass_delay_n.sv
// Scoreboard bench for outpass_delay_n (default parameters).
module tb_outpass_delay_n;

    localparam int NCH  = 4;
    localparam int MAXD = 3;
    localparam int DW   = 2;
    localparam int L    = NCH * DW;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       mode = 1'b0;
    logic       cin  = 1'b0;
    logic       ce   = 1'b1;
    logic [3:0] din  = 4'h0;
    logic [3:0] dout;
    logic       cout;

    always #5 clk = ~clk;

    outpass_delay_n #(
        .NUM_CH   (NCH),
        .MAX_DEPTH(MAXD)
    ) dut (
        .UserCLK(clk),
        .RESETn (rstn),
`ifdef OUTPASS_DELAY_CE_EN
        .CE     (ce),
`endif
        .I      (din),
        .O      (dout),
        .MODE   (mode),
        .CONFin (cin),
        .CONFout(cout)
    );

    typedef struct packed {
        logic [3:0] o;
        logic       co;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: shifted-bit history, committed depths, I history since flush
    bit         bits_m[$];
    logic [3:0] hist_m[$];
    int         act_m[NCH];
    bit         mode_prev;

    function automatic void model_reset();
        bits_m.delete();
        hist_m.delete();
        foreach (act_m[k]) act_m[k] = 0;
        mode_prev = 1'b0;
    endfunction

    function automatic int sh_bit(int i);
        if (i < bits_m.size()) return int'(bits_m[bits_m.size() - 1 - i]);
        return 0;
    endfunction

    function automatic bit stage_enable();
`ifdef OUTPASS_DELAY_CE_EN
        return ce;
`else
        return 1'b1;
`endif
    endfunction

    // Apply one rising edge to the model using the inputs currently driven
    function automatic void model_edge();
        if (!rstn) return;
        if (!mode && mode_prev) begin
            for (int k = 0; k < NCH; k++)
                act_m[k] = 2 * sh_bit(k * DW + 1) + sh_bit(k * DW);
            hist_m.delete();
        end else if (stage_enable()) begin
            hist_m.push_back(din);
            if (hist_m.size() > MAXD) void'(hist_m.pop_front());
        end
        if (mode) begin
            bits_m.push_back(cin);
            if (bits_m.size() > L) void'(bits_m.pop_front());
        end
        mode_prev = mode;
    endfunction

    function automatic exp_t expect_now();
        exp_t       r;
        logic [3:0] h;
        int         d;
        r.co = (bits_m.size() == L) ? bits_m[0] : 1'b0;
        for (int k = 0; k < NCH; k++) begin
            d = act_m[k];
            if (d > MAXD) d = MAXD;
            if (d == 0) begin
                r.o[k] = din[k];
            end else if (hist_m.size() >= d) begin
                h = hist_m[hist_m.size() - d];
                r.o[k] = h[k];
            end else begin
                r.o[k] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic cyc(input logic [3:0] i, input logic m, input logic c,
                       input logic e = 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        din  = i;
        mode = m;
        cin  = c;
        ce   = e;
        exp_q.push_back(expect_now());
    endtask

    task automatic rst_assert(input logic [3:0] i);
        @(posedge clk);
        model_edge();
        #1;
        rstn = 1'b0;
        model_reset();
        din  = i;
        mode = 1'b0;
        cin  = 1'b0;
        exp_q.push_back(expect_now());
    endtask

    task automatic rst_release();
        @(posedge clk);
        model_edge();
        #1;
        rstn = 1'b1;
        exp_q.push_back(expect_now());
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int n = 7; n >= 0; n--)
            cyc(4'($urandom_range(0, 15)), 1'b1, b[n]);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e.o) begin
                errors++;
                $display("FAIL O: got %b expected %b at %0t", dout, e.o, $time);
            end
            checks++;
            if (cout !== e.co) begin
                errors++;
                $display("FAIL CONFout: got %b expected %b at %0t", cout, e.co, $time);
            end
        end
    end

    initial begin
        model_reset();
        // reset state, then release; depth 0 passes I straight through
        rst_assert(4'b0011);
        cyc(4'b1100, 1'b0, 1'b0);
        rst_release();
        cyc(4'b1010, 1'b0, 1'b0);
        cyc(4'b0101, 1'b0, 1'b0);
        cyc(4'b1010, 1'b0, 1'b0);

        // depths ch3=3 ch2=2 ch1=1 ch0=0, then a one-cycle pulse
        for (int n = 7; n >= 0; n--) begin
            logic [7:0] cfg;
            cfg = 8'b11_10_01_00;
            cyc(4'b0000, 1'b1, cfg[n]);
        end
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) cyc(4'b0000, 1'b0, 1'b0);

        // all channels depth 2, then reshift while I toggles
        shift_byte(8'b10_10_10_10);
        cyc(4'b0101, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) cyc(n[0] ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
        for (int n = 7; n >= 0; n--) begin
            logic [7:0] cfg;
            cfg = 8'b10_10_10_10;
            cyc(n[0] ? 4'b1111 : 4'b0000, 1'b1, cfg[n]);
        end
        for (int n = 0; n < 6; n++) cyc(n[0] ? 4'b1010 : 4'b0101, 1'b0, 1'b0);

        // 16-bit stream through the chain to watch CONFout
        for (int n = 15; n >= 0; n--) begin
            logic [15:0] pat;
            pat = 16'hA5C3;
            cyc(4'($urandom_range(0, 15)), 1'b1, pat[n]);
        end
        cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);

        // single-cycle MODE pulse still commits
        cyc(4'($urandom_range(0, 15)), 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);

        // reset mid-shift, then a full reshift
        for (int n = 0; n < 4; n++) cyc(4'($urandom_range(0, 15)), 1'b1, 1'b1);
        rst_assert(4'b0110);
        cyc(4'b1001, 1'b1, 1'b1);
        rst_release();
        cyc(4'b1001, 1'b0, 1'b0);
        shift_byte(8'($urandom_range(0, 255)));
        for (int n = 0; n < 10; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);

`ifdef OUTPASS_DELAY_CE_EN
        // depth 2 with CE low for three cycles mid-stream
        shift_byte(8'b10_10_10_10);
        for (int n = 0; n < 4; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);
`endif

        // random soak
        for (int n = 0; n < 400; n++) begin
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
